// File: rtl/perf_pkg.sv
// perf_pkg: register map, legacy decode constants and CTRL packing for the perf counter bank
package perf_pkg;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_SNAP = 2;
    localparam int CTRL_MODE = 3;
    localparam int CTRL_OVF  = 8;
    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_LIVE_LO = 2'd1,
        REG_SNAP_LO = 2'd2,
        REG_SNAP_HI = 2'd3
    } reg_e;
    localparam logic [31:0] LEG_CTRL_ADDR = 32'hFFFF_FFF4;
    localparam logic [31:0] LEG_READ_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] MAGIC_ON      = 32'hAFA5_1A91;
    localparam logic [31:0] MAGIC_OFF     = 32'h0AFA_5109;
    localparam logic [2:0]  SIZE_WORD     = 3'b010;
    function automatic logic [31:0] ctrl_word(input logic ovf, input logic mode, input logic en);
        logic [31:0] w;
        w = '0;
        w[CTRL_OVF]  = ovf;
        w[CTRL_MODE] = mode;
        w[CTRL_EN]   = en;
        return w;
    endfunction
endpackage

// File: rtl/perf_counter_channel.sv
// perf_counter_channel: one counter with enable, mode, one-shot clear/snapshot and sticky overflow
module perf_counter_channel
    import perf_pkg::*;
#(
    parameter int                   CNT_WIDTH = 32,
    parameter logic [CNT_WIDTH-1:0] RST_CNT   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_we,
    input  logic [31:0]          wdata,
    input  logic                 event_i,
    output logic [31:0]          live,
    output logic [CNT_WIDTH-1:0] snap,
    output logic                 en,
    output logic                 mode,
    output logic                 ovf
);
    logic [CNT_WIDTH-1:0] count;
    logic inc, clr, unused_wdata;
    assign inc = en & (~mode | event_i);
    assign clr = ctrl_we & wdata[CTRL_CLR];
    assign live = count[31:0];
    assign unused_wdata = ^{wdata[31:9], wdata[7:4]};
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_CNT;
            snap  <= '0;
            en    <= 1'b0;
            mode  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= clr ? '0 : count + CNT_WIDTH'(inc);
            // a wrap in the same cycle as a W1C still leaves OVF set
            ovf   <= (inc & ~clr & (&count)) | (ovf & ~(ctrl_we & wdata[CTRL_OVF]));
            if (ctrl_we && wdata[CTRL_SNAP])
                snap <= count;
            if (ctrl_we) begin
                en   <= wdata[CTRL_EN];
                mode <= wdata[CTRL_MODE];
            end
        end
    end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped bank of performance counters with legacy channel-0 decode
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int          NUM_CNT   = 4,
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FE00,
    parameter bit          LEGACY_EN = 1'b1,
    parameter logic [63:0] RST_CNT   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        dmemAddr,
    input  logic [31:0]        dmemWdata,
    input  logic               dmemWen,
    input  logic [2:0]         dmemSize,
    input  logic [NUM_CNT-1:0] event_i,
    output logic               mmioHit,
    output logic [31:0]        mmioRdata
);
    localparam logic [31:0] WIN_BYTES = 32'(NUM_CNT * 16);
    logic [31:0] offset;
    logic in_win, leg_ctrl, leg_read, wr, leg_we;
    logic [3:0] ch;
    reg_e rsel;
    logic [31:0] live [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap [NUM_CNT];
    logic [NUM_CNT-1:0] en, mode, ovf;
    logic [63:0] snap_ext;
    assign offset   = dmemAddr - BASE_ADDR;
    assign in_win   = offset < WIN_BYTES;
    assign ch       = offset[7:4];
    assign rsel     = reg_e'(offset[3:2]);
    assign leg_ctrl = LEGACY_EN && (dmemAddr == LEG_CTRL_ADDR);
    assign leg_read = LEGACY_EN && (dmemAddr == LEG_READ_ADDR);
    assign mmioHit  = in_win | leg_ctrl | leg_read;
    assign wr       = dmemWen & mmioHit & (dmemSize == SIZE_WORD);
    assign leg_we   = wr & leg_ctrl & ((dmemWdata == MAGIC_ON) | (dmemWdata == MAGIC_OFF));
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
        logic we_win, we_leg;
        assign we_win = wr & in_win & (ch == 4'(i)) & (rsel == REG_CTRL);
        assign we_leg = (i == 0) & leg_we;
        // legacy toggles only EN, so it is replayed as a CTRL write that keeps MODE
        perf_counter_channel #(
            .CNT_WIDTH(CNT_WIDTH),
            .RST_CNT  (RST_CNT[CNT_WIDTH-1:0])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .ctrl_we(we_win | we_leg),
            .wdata  (we_leg ? ctrl_word(1'b0, mode[i], dmemWdata == MAGIC_ON) : dmemWdata),
            .event_i(event_i[i]),
            .live   (live[i]),
            .snap   (snap[i]),
            .en     (en[i]),
            .mode   (mode[i]),
            .ovf    (ovf[i])
        );
    end
    always_comb begin
        mmioRdata = '0;
        snap_ext  = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (in_win && ch == 4'(i)) begin
                snap_ext  = 64'(snap[i]);
                mmioRdata = rsel == REG_CTRL    ? ctrl_word(ovf[i], mode[i], en[i]) :
                            rsel == REG_LIVE_LO ? live[i] :
                            rsel == REG_SNAP_LO ? snap_ext[31:0] : snap_ext[63:32];
            end
        end
        if (leg_read)
            mmioRdata = live[0];
    end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Memory-mapped bank of `NUM_CNT` performance counters on the core's data-memory port. It replaces the single magic-word cycle counter in the simulation top. Each channel counts either clock cycles or pulses on a per-channel event input, and provides enable, clear, snapshot and sticky overflow. The block decodes its own address window and flags hits, so the top can suppress data-memory writes and steer read data. A legacy decode keeps old firmware working unchanged.

## Interface
- `NUM_CNT`, 4: number of counter channels, 1..16.
- `CNT_WIDTH`, 32: counter width, 32..64.
- `BASE_ADDR`, 32'hFFFF_FE00: window base; window is `NUM_CNT`*16 bytes, 16-byte aligned.
- `LEGACY_EN`, 1: enables the legacy control/read addresses for channel 0.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `dmemAddr`  in  32  core data address.
- `dmemWdata`  in  32  core write data.
- `dmemWen`  in  1  core write strobe.
- `dmemSize`  in  3  access size, funct3 encoding (3'b010 = word).
- `event_i`  in  NUM_CNT  per-channel event pulses, one count per high cycle.
- `mmioHit`  out  1  address is in the window or is a legacy address (when enabled); combinational.
- `mmioRdata`  out  32  read data for the hit address, 0 when no hit; combinational.

## Operation
- Channel i occupies `BASE_ADDR + 16*i`:
  - +0 CTRL: bit0 EN, bit1 CLR, bit2 SNAP, bit3 MODE (0 = cycles, 1 = event), bit8 OVF.
  - +4 LIVE_LO: live count [31:0], read-only.
  - +8 SNAP_LO: snapshot [31:0], read-only.
  - +C SNAP_HI: snapshot [CNT_WIDTH-1:32], zero-extended; reads 0 when CNT_WIDTH = 32.
- A write is accepted only when `dmemWen`, `mmioHit` and `dmemSize` = 3'b010 are all true. Other sizes are ignored: no state change, `mmioHit` still asserts.
- CTRL write:
  - EN and MODE are stored.
  - CLR and SNAP are one-shot and read back as 0.
  - OVF is write-1-to-clear.
- CTRL read returns {OVF at bit8, MODE, 0, 0, EN}.
- Writes to read-only offsets are ignored.
- Increment: when EN is set and (MODE = 0, or `event_i[i]` = 1), count ← count + 1 modulo 2^CNT_WIDTH.
- Overflow: a wrap from all-ones to 0 sets OVF. OVF stays set until W1C or reset.
- SNAP copies the pre-edge count, i.e. the value before that cycle's increment.
- Legacy decode (LEGACY_EN = 1), channel 0 only:
  - Word write of 32'hAFA51A91 to 32'hFFFF_FFF4 sets EN.
  - Word write of 32'h0AFA5109 to 32'hFFFF_FFF4 clears EN.
  - Any other write to that address is ignored.
  - A read of 32'hFFFF_FFF8 returns the live count [31:0].
  - Both addresses assert `mmioHit`.
- The top gates `dmemWen & !mmioHit` into data memory and muxes `mmioRdata` when `mmioHit` is high.

## Timing
- Reset: all counts, snapshots, EN, MODE and OVF are 0. `mmioRdata` then reads 0 at every offset.
- Writes take effect at the rising edge of the write cycle. A read in the following cycle sees the new value.
- Reads are combinational from registered state, with zero-cycle latency.
- Simultaneous events:
  - CLR together with increment: count = 0 and no increment. EN written in the same word takes effect from the next cycle.
  - CLR together with SNAP: the snapshot gets the pre-clear value, and the count becomes 0.
  - Wrap together with OVF W1C: set wins, so OVF = 1.
  - Write EN = 0 in a cycle where an increment is pending: the current cycle's increment still applies, and counting stops after that.
- `rst` asserted mid-count overrides every write and event in that cycle.

## Structure
- Package `perf_pkg`:
  - CTRL bit positions.
  - Register offsets.
  - Legacy addresses.
  - Magic words 32'hAFA51A91 / 32'h0AFA5109.
  - Size code `SIZE_WORD` = 3'b010.
- Sub-module `perf_counter_channel`:
  - Parametrised by CNT_WIDTH.
  - Holds count, snapshot, EN, MODE and OVF.
  - Inputs: `ctrl_we`, `wdata`, `event_i`.
- The top generates `NUM_CNT` instances, plus address decode and the read mux.

## Test plan
- Reset, then read every offset → all 0. Write CTRL0 = 0x1 → LIVE_LO reads 1 in the next cycle and N after N more cycles.
- MODE = 1, EN = 1 on channel 1; pulse `event_i[1]` 5 times spread over 20 cycles → LIVE_LO = 5.
- CNT_WIDTH = 32: load near wrap by running from 0xFFFF_FFF0 (test hook); after 16 increments → count 0, OVF = 1. Write CTRL = 0x101 → OVF = 0, EN kept.
- CNT_WIDTH = 64: SNAP at a count of 0x1_0000_0003 → SNAP_HI = 1, SNAP_LO = 3, unchanged while the live count keeps running. A CLR+SNAP write gives SNAP = old value and live = 0.
- Legacy:
  - Word write of 32'hAFA51A91 to 32'hFFFF_FFF4 → channel 0 counts; a read of 32'hFFFF_FFF8 matches LIVE_LO.
  - Write 32'h0AFA5109 → counting stops.
  - A byte write (`dmemSize` = 0) with either word → no effect.
  - `mmioHit` is high for every access to either address.
